// File: rtl/aes128_dec_core_if.sv
// Stream bundle for the AES-128 decrypt core: ciphertext/key in, plaintext out, valid/ready on both sides.
interface aes128_dec_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_ct;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_pt;

  modport slave (
    input  in_valid, in_ct, in_key, out_ready,
    output in_ready, out_valid, out_pt
  );

  modport master (
    output in_valid, in_ct, in_key, out_ready,
    input  in_ready, out_valid, out_pt
  );
endinterface

// File: rtl/aes128_dec_core.sv
// Iterative AES-128 inverse cipher, one round/clk; latency 20 (10 on key-cache hit), result held until out_ready.
// Optional rk10 cache keyed on the cipher key is enabled by defining AES_DEC_KEY_CACHE_EN.
module aes128_dec_core (
  input logic              clk,
  input logic              rst_n,
  aes128_dec_core_if.slave bus
);
  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} fsm_t;

  fsm_t         fsm, fsm_nxt;
  logic [3:0]   cnt;
  logic [127:0] key_reg, state, ct, pt_q;
  logic [127:0] key_fwd, key_rev, rnd_out;
  logic         accept, cache_hit;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    y = ginv(x);
    return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Byte 0 of a word sits in bits [7:0], so RotWord moves bits [15:8] down to [7:0].
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[7:0], w[31:8]};
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox(r[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] fwd_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[31:0] ^ sub_rot(k[127:96]) ^ {24'd0, rc};
    w1 = k[63:32] ^ w0;
    w2 = k[95:64] ^ w1;
    w3 = k[127:96] ^ w2;
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [127:0] rev_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[127:96] ^ k[95:64];
    p2 = k[95:64] ^ k[63:32];
    p1 = k[63:32] ^ k[31:0];
    p0 = k[31:0] ^ sub_rot(p3) ^ {24'd0, rc};
    return {p3, p2, p1, p0};
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic mix);
    logic [127:0] t, m;
    logic [7:0]   a0, a1, a2, a3;
    t = '0;
    m = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[32*c + 8*r +: 8] = inv_sbox(s[32*((c - r + 4) % 4) + 8*r +: 8]);
    t = t ^ rk;
    for (int c = 0; c < 4; c++) begin
      a0 = t[32*c +: 8];
      a1 = t[32*c + 8 +: 8];
      a2 = t[32*c + 16 +: 8];
      a3 = t[32*c + 24 +: 8];
      m[32*c +: 8]      = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      m[32*c + 8 +: 8]  = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      m[32*c + 16 +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      m[32*c + 24 +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return mix ? m : t;
  endfunction

  // cnt is the KEXP step minus one, then the current round index r during ROUND.
  assign accept  = bus.in_valid & bus.in_ready;
  assign key_fwd = fwd_key(key_reg, rcon(cnt + 4'd1));
  assign key_rev = rev_key(key_reg, rcon(cnt + 4'd1));
  assign rnd_out = inv_round(state, key_rev, cnt != 4'd0);

  assign bus.in_ready  = (fsm == IDLE);
  assign bus.out_valid = (fsm == DONE);
  assign bus.out_pt    = pt_q;

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] cached_key, cached_rk10;
  logic         cache_valid;

  assign cache_hit = cache_valid && (bus.in_key == cached_key);

  // The key is captured at accept since key_reg no longer holds it once KEXP ends;
  // the entry only becomes valid when rk10 lands, so an aborted run leaves it invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid <= 1'b0;
      cached_key  <= '0;
      cached_rk10 <= '0;
    end else if (accept && !cache_hit) begin
      cache_valid <= 1'b0;
      cached_key  <= bus.in_key;
    end else if (fsm == KEXP && cnt == 4'd9) begin
      cache_valid <= 1'b1;
      cached_rk10 <= key_fwd;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (accept) fsm_nxt = cache_hit ? ROUND : KEXP;
      KEXP:    if (cnt == 4'd9) fsm_nxt = ROUND;
      ROUND:   if (cnt == 4'd0) fsm_nxt = DONE;
      DONE:    if (bus.out_ready) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      key_reg <= '0;
      state   <= '0;
      ct      <= '0;
      pt_q    <= '0;
    end else begin
      case (fsm)
        IDLE: if (accept) begin
          ct      <= bus.in_ct;
          key_reg <= bus.in_key;
          cnt     <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
          if (cache_hit) begin
            state   <= bus.in_ct ^ cached_rk10;
            key_reg <= cached_rk10;
            cnt     <= 4'd9;
          end
`endif
        end
        KEXP: begin
          key_reg <= key_fwd;
          if (cnt == 4'd9) state <= ct ^ key_fwd;
          else             cnt   <= cnt + 4'd1;
        end
        ROUND: begin
          key_reg <= key_rev;
          state   <= rnd_out;
          if (cnt == 4'd0) pt_q <= rnd_out;
          else             cnt  <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_dec_core.sv
// Scoreboard bench for aes128_dec_core: directed FIPS-197 vectors, backpressure, busy input, mid-op reset.
module tb_aes128_dec_core;
  localparam logic [127:0] K1  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] CT1 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] PT1 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] K0  = 128'h0;
  localparam logic [127:0] CT0 = 128'h2e2b34ca59fa4c883b2c8aefd44be966;
  localparam logic [127:0] PT0 = 128'h0;
`ifdef AES_DEC_KEY_CACHE_EN
  localparam int LAT_HIT = 10;
`else
  localparam int LAT_HIT = 20;
`endif

  typedef struct {
    logic [127:0] pt;
    int           lat;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes128_dec_core_if bus ();
  aes128_dec_core dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation on each new out_valid, checks hold behaviour and post-handshake in_ready.
  logic         prev_vld = 1'b0;
  logic         chk_rdy = 1'b0;
  logic [127:0] hold_pt = '0;
  exp_t         e;
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prev_vld = 1'b0;
      chk_rdy  = 1'b0;
    end else begin
      if (chk_rdy) begin
        chk("in_ready_after_handshake", {127'd0, bus.in_ready}, 128'd1);
        chk_rdy = 1'b0;
      end
      if (bus.out_valid === 1'b1 && !prev_vld) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: out_valid=1 pt=%h, required no output", bus.out_pt);
        end else begin
          e = sb.pop_front();
          chk("out_pt", bus.out_pt, e.pt);
          chk("latency", 128'(cyc - e.acc), 128'(e.lat));
        end
        hold_pt = bus.out_pt;
      end else if (bus.out_valid === 1'b1) begin
        chk("held_out_pt", bus.out_pt, hold_pt);
        chk("held_in_ready", {127'd0, bus.in_ready}, 128'd0);
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) chk_rdy = 1'b1;
      prev_vld = (bus.out_valid === 1'b1);
    end
  end

  task automatic send(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p,
                      input int lat, input bit track);
    int   n;
    exp_t x;
    n = 0;
    @(posedge clk); #1;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_in_ready", {127'd0, bus.in_ready}, 128'd1);
    if (bus.in_ready === 1'b1) begin
      bus.in_valid = 1'b1;
      bus.in_key   = k;
      bus.in_ct    = c;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_key   = '0;
      bus.in_ct    = '0;
      if (track) begin
        x.pt  = p;
        x.lat = lat;
        x.acc = cyc;
        sb.push_back(x);
      end
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid === 1'b1 || bus.in_ready !== 1'b1) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (n >= 300) begin
      fails++;
      $display("FAIL drain_%s: timed out, pending=%0d, required 0", name, sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_ct     = '0;
    bus.in_key    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {127'd0, bus.in_ready}, 128'd1);
    chk("reset_out_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("reset_out_pt", bus.out_pt, 128'd0);
    rst_n = 1'b1;

    send(K1, CT1, PT1, 20, 1'b1);
    drain("c1");
    send(K1, CT1, PT1, LAT_HIT, 1'b1);
    drain("c1_repeat");
    send(K0, CT0, PT0, 20, 1'b1);
    drain("zero_key");

    // Backpressure: keep out_ready low for 7 cycles of out_valid.
    bus.out_ready = 1'b0;
    send(K1, CT1, PT1, 20, 1'b1);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_out_valid_seen", {127'd0, bus.out_valid}, 128'd1);
    repeat (7) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    drain("backpressure");

    // Busy input: a competing offer mid-ROUND must leave the result untouched.
    send(K1, CT1, PT1, LAT_HIT, 1'b1);
    repeat (LAT_HIT - 8) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_key   = K0;
    bus.in_ct    = CT0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain("busy");

    // Reset mid-op after the cache would have been filled with K1.
    send(K0, CT0, PT0, 20, 1'b1);
    drain("zero_key_2");
    send(K1, CT1, PT1, 20, 1'b0);
    repeat (12) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    #1;
    chk("post_reset_in_ready", {127'd0, bus.in_ready}, 128'd1);
    chk("post_reset_out_valid", {127'd0, bus.out_valid}, 128'd0);
    repeat (25) begin
      @(posedge clk); #1;
    end
    send(K1, CT1, PT1, 20, 1'b1);
    drain("after_reset");

    chk("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
